layer_mac_array: RTL and testbench
==================================

// Module: layer_mac_array
// PURPOSE
//  Parametrised fully-connected layer engine for the MNIST accelerator: NUM_NEURONS neurons share one
//  streamed input x and each owns a streamed weight lane. Each neuron accumulates NUM_INPUTS products,
//  adds its bias, then applies ReLU or passes the value through (bypass mode, for output logits).
//  The controller starts it, waits for done, and reads results back to memory through a registered mux.
// PARAMETERS
//  NUM_NEURONS  10  neurons (weight lanes / result words)
//  NUM_INPUTS   784 x samples per inference; >=1
//  DATA_W       32  width of x, w, b and result words (signed two's complement)
//  FRAC         16  fractional bits (Q(DATA_W-FRAC).FRAC); FRAC < DATA_W
//  ACC_W        48  accumulator width; ACC_W >= DATA_W+8
//  SEL_W        4   width of readout select; 2**SEL_W >= NUM_NEURONS
// PORTS
//  clock_layer_in      in   1                  clock, all logic on rising edge
//  rst_n_layer_in      in   1                  async active-low reset
//  head_c2layer        in   1                  start pulse; (re)starts an inference
//  relu_bypass_c2layer in   1                  1 = no ReLU; sampled on head_c2layer
//  x_valid_mem2layer   in   1                  x/w beat valid
//  x_ready_layer2mem   out  1                  layer accepts beat (state ACC)
//  x_mem2layer         in   DATA_W             shared input sample
//  w_mem2layer         in   NUM_NEURONS*DATA_W weight lanes; lane i = [i*DATA_W +: DATA_W]
//  b_mem2layer         in   NUM_NEURONS*DATA_W bias lanes; sampled in FIN
//  data_sel_c2layer    in   SEL_W              readout neuron index
//  data_layer2mem      out  DATA_W             registered result of selected neuron
//  done_flag_layer2c   out  1                  all results valid
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE, accumulators, beat counter, results,
//    data_layer2mem = 0; x_ready_layer2mem = 0; done_flag_layer2c = 0; bypass latch = 0.
//  - FSM IDLE -> ACC -> FIN -> DONE. head_c2layer in any state: clear accumulators and counter,
//    latch relu_bypass, drop done, enter ACC next cycle. head takes priority over all other events.
//  - ACC: x_ready=1. Beat accepted when x_valid & x_ready. Per beat, per lane:
//    p = (x*w) as 2*DATA_W signed, arithmetic shift right FRAC (truncate toward -inf),
//    sign-extend to ACC_W, acc += p (ACC_W wrap, not saturated). Counter +1.
//    Accepting beat NUM_INPUTS (counter == NUM_INPUTS-1) -> FIN. No valid -> wait, no timeout.
//  - FIN (1 cycle, x_ready=0): s = acc + sext(b_i); ReLU: s<0 -> 0 unless bypass;
//    saturate to DATA_W signed ([-2^(DATA_W-1), 2^(DATA_W-1)-1]); store result_i. -> DONE.
//  - DONE: done_flag=1, held until next head or reset. Results held until next FIN.
//  - Latency: head at cycle 0, ready from cycle 1; with valid held high, done asserts
//    NUM_INPUTS+2 cycles after head.
//  - Readout: every cycle data_layer2mem <= (sel < NUM_NEURONS) ? result[sel] : 0; 1-cycle
//    latency, active in every state (shows previous results during ACC).
//  - Reset mid-ACC: everything to reset values; partial sums discarded.
//  - Beats presented outside ACC are ignored (ready=0).
// TESTING (NUM_NEURONS=10, NUM_INPUTS=4, DATA_W=32, FRAC=16)
//  1 reset released, no head -> done=0, ready=0, data_layer2mem=0 for sel 0..15.
//  2 x=0x00010000, all w=0x00008000, b=0, 4 beats back-to-back -> done 6 cycles after head;
//    every result 0x00020000; sel=3 -> 0x00020000 next cycle; sel=12 -> 0.
//  3 as 2 but lane 0 w=0xFFFF8000: bypass=0 -> result0=0; bypass=1 -> result0=0xFFFE0000;
//    b1=0x00010000 -> result1=0x00030000.
//  4 x=0x7FFF0000, w=0x00020000, 4 beats -> all 0x7FFFFFFF (saturated); w negated, bypass=1 -> 0x80000000.
//  5 valid gaps (beats on cycles 1,3,4,7) -> same results as 2, done one cycle after FIN.
//  6 head after 2 beats (abort) and reset mid-ACC -> restart gives clean results of 2;
//    after reset, done=0 and data=0.

Source files
------------

// File: rtl/layer_mac_array.sv
// layer_mac_array: fully-connected layer engine, NUM_NEURONS lanes sharing a streamed x,
// each accumulating x*w in fixed point, then bias, optional ReLU and saturation.
module layer_mac_array #(
  parameter int NUM_NEURONS = 10,
  parameter int NUM_INPUTS  = 784,
  parameter int DATA_W      = 32,
  parameter int FRAC        = 16,
  parameter int ACC_W       = 48,
  parameter int SEL_W       = 4
) (
  input  logic                          clock_layer_in,
  input  logic                          rst_n_layer_in,
  input  logic                          head_c2layer,
  input  logic                          relu_bypass_c2layer,
  input  logic                          x_valid_mem2layer,
  output logic                          x_ready_layer2mem,
  input  logic [DATA_W-1:0]             x_mem2layer,
  input  logic [NUM_NEURONS*DATA_W-1:0] w_mem2layer,
  input  logic [NUM_NEURONS*DATA_W-1:0] b_mem2layer,
  input  logic [SEL_W-1:0]              data_sel_c2layer,
  output logic [DATA_W-1:0]             data_layer2mem,
  output logic                          done_flag_layer2c
);
  localparam int CNT_W = NUM_INPUTS > 1 ? $clog2(NUM_INPUTS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_INPUTS - 1);
  localparam logic [SEL_W:0] NN = (SEL_W + 1)'(NUM_NEURONS);
  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, FIN, DONE} state_t;

  state_t                  state;
  logic                    bypass;
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc     [NUM_NEURONS];
  logic signed [ACC_W-1:0] acc_nxt [NUM_NEURONS];
  logic [DATA_W-1:0]       fin_v   [NUM_NEURONS];
  logic [DATA_W-1:0]       result  [NUM_NEURONS];

  assign x_ready_layer2mem = state == ACC;
  assign done_flag_layer2c = state == DONE;

  for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_lane
    logic signed [DATA_W-1:0]   x_s, w_s, b_s;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    sum, relu_s;
    assign x_s  = x_mem2layer;
    assign w_s  = w_mem2layer[g*DATA_W +: DATA_W];
    assign b_s  = b_mem2layer[g*DATA_W +: DATA_W];
    assign prod = (2*DATA_W)'(x_s) * (2*DATA_W)'(w_s);
    assign acc_nxt[g] = acc[g] + ACC_W'(prod >>> FRAC);
    assign sum    = acc[g] + ACC_W'(b_s);
    assign relu_s = (!bypass && sum < 0) ? '0 : sum;
    // Clamp the wide sum into the signed result word range.
    assign fin_v[g] = relu_s > MAX_V ? DATA_W'(MAX_V) : relu_s < MIN_V ? DATA_W'(MIN_V) : DATA_W'(relu_s);
  end

  always_ff @(posedge clock_layer_in or negedge rst_n_layer_in) begin
    if (!rst_n_layer_in) begin
      state          <= IDLE;
      bypass         <= 1'b0;
      cnt            <= '0;
      data_layer2mem <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        acc[i]    <= '0;
        result[i] <= '0;
      end
    end else begin
      data_layer2mem <= ({1'b0, data_sel_c2layer} < NN) ? result[data_sel_c2layer] : '0;
      if (head_c2layer) begin
        state  <= ACC;
        bypass <= relu_bypass_c2layer;
        cnt    <= '0;
        for (int i = 0; i < NUM_NEURONS; i++) acc[i] <= '0;
      end else begin
        case (state)
          ACC: if (x_valid_mem2layer) begin
            for (int i = 0; i < NUM_NEURONS; i++) acc[i] <= acc_nxt[i];
            cnt   <= cnt + 1'b1;
            state <= cnt == LAST ? FIN : ACC;
          end
          FIN: begin
            for (int i = 0; i < NUM_NEURONS; i++) result[i] <= fin_v[i];
            state <= DONE;
          end
          default: state <= state;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_layer_mac_array.sv
// tb_layer_mac_array: directed stimulus against a transaction-level model of the layer engine.
module tb_layer_mac_array;
  localparam int NN = 10, NI = 4, DW = 32, FR = 16, AW = 48, SW = 4;

  logic clk = 0, rst_n = 0, head = 0, byp = 0, valid = 0;
  logic [DW-1:0] x = '0;
  logic [NN*DW-1:0] w = '0, b = '0;
  logic [SW-1:0] sel = '0;
  logic ready, done;
  logic [DW-1:0] data;
  int checks = 0, errors = 0;
  bit on = 0;

  always #5 clk = ~clk;

  layer_mac_array #(.NUM_NEURONS(NN), .NUM_INPUTS(NI), .DATA_W(DW), .FRAC(FR), .ACC_W(AW), .SEL_W(SW)) dut (
    .clock_layer_in(clk), .rst_n_layer_in(rst_n), .head_c2layer(head), .relu_bypass_c2layer(byp),
    .x_valid_mem2layer(valid), .x_ready_layer2mem(ready), .x_mem2layer(x), .w_mem2layer(w),
    .b_mem2layer(b), .data_sel_c2layer(sel), .data_layer2mem(data), .done_flag_layer2c(done));

  // Model: captures accepted beats, then evaluates each neuron with plain 64-bit arithmetic.
  bit m_run, m_fin, m_done, m_byp;
  int m_n;
  logic [DW-1:0] mx [NI];
  logic [DW-1:0] mw [NN][NI];
  logic [DW-1:0] m_res [NN];
  logic [DW-1:0] m_data;

  function automatic longint wrap(input longint v);
    return (v <<< (64 - AW)) >>> (64 - AW);
  endfunction

  function automatic logic [DW-1:0] neuron(input int i);
    longint acc = 0, s;
    for (int k = 0; k < NI; k++)
      acc = wrap(acc + ((longint'($signed(mx[k])) * longint'($signed(mw[i][k]))) >>> FR));
    s = wrap(acc + longint'($signed(b[i*DW +: DW])));
    if (!m_byp && s < 0) s = 0;
    if (s > 64'sd2147483647) return 32'h7fffffff;
    if (s < -64'sd2147483648) return 32'h80000000;
    return s[31:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_fin = 0; m_done = 0; m_byp = 0; m_n = 0; m_data = '0;
      for (int i = 0; i < NN; i++) m_res[i] = '0;
    end else begin
      m_data = (int'(sel) < NN) ? m_res[sel] : '0;
      if (head) begin
        m_run = 1; m_fin = 0; m_done = 0; m_n = 0; m_byp = byp;
      end else if (m_fin) begin
        for (int i = 0; i < NN; i++) m_res[i] = neuron(i);
        m_fin = 0; m_done = 1;
      end else if (m_run && valid) begin
        mx[m_n] = x;
        for (int i = 0; i < NN; i++) mw[i][m_n] = w[i*DW +: DW];
        m_n++;
        if (m_n == NI) begin m_run = 0; m_fin = 1; end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (on) begin
    chk("ready", 32'(ready), 32'(m_run));
    chk("done", 32'(done), 32'(m_done));
    chk("data", data, m_data);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_w(input logic [31:0] v);
    for (int i = 0; i < NN; i++) w[i*DW +: DW] = v;
  endtask

  task automatic head_pulse(input bit bp);
    head = 1; byp = bp; step(); head = 0;
  endtask

  task automatic run(input bit bp, input logic [15:0] pat, input int ncyc, input int exp_lat, input string n);
    int lat;
    head_pulse(bp);
    lat = 1;
    for (int c = 0; c < ncyc; c++) begin valid = pat[c]; step(); lat++; end
    valid = 0;
    while (!done && lat < 40) begin step(); lat++; end
    chk(n, 32'(lat), 32'(exp_lat));
  endtask

  task automatic rd(input logic [SW-1:0] s, input logic [31:0] exp, input string n);
    sel = s; step(); chk(n, data, exp);
  endtask

  initial begin
    step(); step(); rst_n = 1; on = 1;
    chk("t1_done", 32'(done), 0);
    chk("t1_ready", 32'(ready), 0);
    for (int s = 0; s < 16; s++) rd(SW'(s), 32'h0, "t1_data");
    x = 32'h00010000; set_w(32'h00008000);
    run(0, 16'hf, 4, 6, "t2_lat");
    rd(3, 32'h00020000, "t2_sel3");
    rd(12, 32'h0, "t2_sel12");
    rd(9, 32'h00020000, "t2_sel9");
    w[0 +: DW] = 32'hFFFF8000;
    run(0, 16'hf, 4, 6, "t3_lat");
    rd(0, 32'h0, "t3_relu");
    run(1, 16'hf, 4, 6, "t3_lat_byp");
    rd(0, 32'hFFFE0000, "t3_bypass");
    b[DW +: DW] = 32'h00010000;
    run(1, 16'hf, 4, 6, "t3_lat_bias");
    rd(1, 32'h00030000, "t3_bias");
    b = '0; x = 32'h7FFF0000; set_w(32'h00020000);
    run(0, 16'hf, 4, 6, "t4_lat");
    rd(0, 32'h7FFFFFFF, "t4_satp");
    set_w(32'hFFFE0000);
    run(1, 16'hf, 4, 6, "t4_lat_neg");
    rd(5, 32'h80000000, "t4_satn");
    x = 32'h00010000; set_w(32'h00008000);
    run(0, 16'b1001101, 7, 9, "t5_lat");
    rd(2, 32'h00020000, "t5_res");
    head_pulse(0);
    x = 32'h00040000; valid = 1; step(); step(); valid = 0; x = 32'h00010000;
    run(0, 16'hf, 4, 6, "t6_lat_abort");
    rd(4, 32'h00020000, "t6_abort");
    head_pulse(0);
    x = 32'h00040000; valid = 1; step(); step();
    rst_n = 0; valid = 0; x = 32'h00010000; #1;
    chk("t6_rst_done", 32'(done), 0);
    chk("t6_rst_data", data, 32'h0);
    step(); rst_n = 1; step();
    chk("t6_rst_data2", data, 32'h0);
    run(0, 16'hf, 4, 6, "t6_lat_rst");
    rd(7, 32'h00020000, "t6_rst_res");
    step();
    on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
